rr_arbiter_mux: RTL and testbench
=================================

// Module: rr_arbiter_mux
//
// PURPOSE
// - Shares one output channel between N_REQ requesters using round-robin arbitration.
// - Each requester presents valid/data. The block grants one requester per accepted
//   transfer and steers that requester's data through a select mux into a
//   one-entry output register.
// - Sits between producer ports and a single shared consumer. The consumer side
//   uses a valid/ready handshake.
//
// PARAMETERS
// - N_REQ  4   number of requesters, >= 2
// - WIDTH  8   data width per requester
//
// PORTS
// - clk        in   1              clock; all state updates on posedge
// - rst        in   1              synchronous reset, active-high
// - in_valid   in   N_REQ          per-requester data valid
// - in_data    in   N_REQ*WIDTH    requester i data at [i*WIDTH +: WIDTH]
// - in_ready   out  N_REQ          one-hot or zero; requester i transfer accepted this cycle
// - out_valid  out  1              output register holds data
// - out_data   out  WIDTH          registered granted data
// - out_src    out  $clog2(N_REQ)  index of requester that produced out_data
// - out_ready  in   1              consumer accepts out_data this cycle
//
// BEHAVIOUR
// - Reset (rst=1 at posedge):
//   - out_valid=0, out_data=0, out_src=0.
//   - Priority pointer ptr=0, so requester 0 has highest priority.
//   - in_ready is 0 during reset.
// - Slot free: free = !out_valid || out_ready. A drain and a load in the same
//   cycle are permitted, giving full throughput of one transfer per cycle.
// - Pick: sel = first i with in_valid[i]=1, searching ptr, ptr+1, ..., N_REQ-1,
//   0, ..., ptr-1 (wraps). Purely combinational.
// - in_ready[sel] = free && |in_valid. All other in_ready bits are 0.
//   in_ready never depends on in_valid of a different requester beyond the pick.
// - Load (free && |in_valid):
//   - out_data <= in_data[sel], out_src <= sel, out_valid <= 1.
//   - ptr <= (sel == N_REQ-1) ? 0 : sel+1.
// - Drain with no load (out_ready && out_valid && !|in_valid): out_valid <= 0.
//   out_data and out_src hold their last value.
// - Stall (out_valid && !out_ready):
//   - All of out_valid, out_data, out_src and ptr hold. in_ready = 0.
// - Latency: a transfer accepted at cycle t is visible on out_* at t+1.
// - Two states, encoded by out_valid:
//   - EMPTY -> FULL on load.
//   - FULL -> FULL on stall, or on load while draining.
//   - FULL -> EMPTY on drain without load.
// - ptr changes only on load, never on stall or idle, so a requester held
//   waiting is guaranteed service within N_REQ accepted transfers.
// - Reset mid-transfer discards the registered data and returns the pointer to 0.
// - out_ready while out_valid=0 is ignored.
//
// STRUCTURE
// - No shared package required. Local parameter: IDX_W = $clog2(N_REQ).
// - Sub-module rr_pick: combinational; inputs req[N_REQ] and ptr; outputs
//   sel[IDX_W] and any.
// - Data steering: N_REQ:1 select mux on in_data indexed by sel, built from
//   2:1 mux instances or an equivalent indexed part-select.
// - The rest is flat: free/load logic plus the out_*/ptr registers.
//
// TESTING (N_REQ=4, WIDTH=8)
// - Reset: hold rst 2 cycles with in_valid=4'b1111
//     -> out_valid=0, out_data=0, in_ready=0; first load after reset grants req0.
// - Fairness: in_valid=4'b1111 constant, data i=8'hA0+i, out_ready=1
//     -> out_src sequence 0,1,2,3,0, one per cycle; data A0,A1,A2,A3,A0.
// - Skip/wrap: ptr=3, in_valid=4'b0101
//     -> grant req0 (wraps past 3); next cycle grant req2; then req0.
// - Backpressure: out_ready=0 with out_valid=1 for 3 cycles
//     -> out_data/out_src stable, in_ready=0, ptr unchanged.
//     Then out_ready=1 -> drain and next load in the same cycle.
// - Idle drain: single req1 beat 8'h5C, then in_valid=0, out_ready=1
//     -> out_valid 1 for exactly one cycle with out_src=1; next grant search starts at 2.
// - Reset mid-stall: out_valid=1, out_ready=0, assert rst
//     -> next cycle out_valid=0, ptr=0.

Source files
------------

// File: rtl/rr_arbiter_mux_pkg.sv
// Shared types for the round-robin arbiter/mux: the output-slot state encoding.
package rr_arbiter_mux_pkg;

  // The slot state is carried directly on out_valid: EMPTY=0, FULL=1.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arbiter_mux_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] sel,
  output logic             any
);

  int j;

  // Walk the rotation from farthest to nearest so the nearest valid request wins.
  always_comb begin
    sel = '0;
    j   = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N_REQ;
      if (req[j]) sel = IDX_W'(j);
    end
    any = |req;
  end

endmodule

// File: rtl/rr_arbiter_mux.sv
// Round-robin arbiter steering one of N_REQ requesters into a one-entry output register.
module rr_arbiter_mux
  import rr_arbiter_mux_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           in_valid,
  input  logic [N_REQ*WIDTH-1:0]     in_data,
  output logic [N_REQ-1:0]           in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(N_REQ)-1:0]   out_src,
  input  logic                       out_ready
);

  localparam int IDX_W = $clog2(N_REQ);

  // Handshake: a beat moves on a port when valid && ready are both high at posedge.
  // in_ready is one-hot on the picked requester whenever the slot is free; the
  // slot is free when empty or being drained this same cycle (out_valid && out_ready).

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q;
  logic [IDX_W-1:0]  sel;
  logic              any;
  logic              free;
  logic              load;
  logic [WIDTH-1:0]  sel_data;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req (in_valid),
    .ptr (ptr_q),
    .sel (sel),
    .any (any)
  );

  assign out_valid = (state_q == FULL);
  assign free      = !out_valid || out_ready;
  assign load      = !rst && free && any;
  assign sel_data  = in_data[sel*WIDTH +: WIDTH];

  always_comb begin
    in_ready = '0;
    if (load) in_ready[sel] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (load) state_d = FULL;
      FULL:  if (!load && out_ready) state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  // Pointer moves only on a load, which bounds any waiting requester's delay.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= '0;
      out_src  <= '0;
      ptr_q    <= '0;
    end else if (load) begin
      out_data <= sel_data;
      out_src  <= sel;
      ptr_q    <= (sel == IDX_W'(N_REQ - 1)) ? '0 : sel + 1'b1;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_mux.sv
// Self-checking bench for rr_arbiter_mux: directed scenarios plus random traffic vs a rotation model.
module tb_rr_arbiter_mux;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [1:0]     out_src;
  logic           out_ready;
  logic [W-1:0]   d [N];

  rr_arbiter_mux #(.N_REQ(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) in_data[i*W +: W] = d[i];
  end

  // scoreboard state
  int n_checks = 0;
  int n_pass   = 0;
  logic [W+1:0] exp_q [$];

  // reference model: the output slot and the priority pointer
  int       m_ptr;
  logic     m_valid;
  logic [W-1:0] m_data;
  int       m_src;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One cycle: drive inputs, check in_ready mid-cycle, clock, check registered outputs.
  task automatic step(input logic r, input logic [N-1:0] v, input logic rdy);
    int order [$];
    int pick;
    logic ld;
    logic [N-1:0] exp_rdy;
    logic [W+1:0] item;
    rst = r; in_valid = v; out_ready = rdy;
    #4;
    pick = -1;
    order = {};
    for (int k = 0; k < N; k++) order.push_back((m_ptr + k) % N);
    foreach (order[k]) if (pick < 0 && v[order[k]]) pick = order[k];
    ld = !r && (!m_valid || rdy) && (pick >= 0);
    exp_rdy = ld ? N'(1 << pick) : '0;
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (ld) exp_q.push_back({2'(pick), d[pick]});
    @(posedge clk);
    #1;
    if (r) begin
      m_valid = 1'b0; m_data = '0; m_src = 0; m_ptr = 0;
    end else if (ld) begin
      m_valid = 1'b1; m_data = d[pick]; m_src = pick; m_ptr = (pick + 1) % N;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("out_data", 32'(out_data), 32'(m_data));
    check("out_src", 32'(out_src), 32'(m_src));
    if (ld) begin
      if (exp_q.size() == 0) check("exp_q_underflow", 32'd1, 32'd0);
      else begin
        item = exp_q.pop_front();
        check("beat", {22'd0, out_src, out_data}, 32'(item));
      end
    end
  endtask

  initial begin
    logic [1:0] seq [5];
    seq = '{0, 1, 2, 3, 0};
    m_ptr = 0; m_valid = 1'b0; m_data = '0; m_src = 0;
    rst = 1'b1; in_valid = '0; out_ready = 1'b0;
    for (int i = 0; i < N; i++) d[i] = W'(8'hA0 + i);
    @(posedge clk); #1;

    // reset held two cycles with all requesters valid
    step(1'b1, 4'b1111, 1'b1);
    step(1'b1, 4'b1111, 1'b1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);

    // fairness: 0,1,2,3,0 with data A0+i
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 4'b1111, 1'b1);
      check("fair_src", 32'(out_src), 32'(seq[k]));
      check("fair_data", 32'(out_data), 32'(8'hA0 + seq[k]));
    end

    // skip/wrap: put ptr at 3, then 4'b0101 grants 0, 2, 0
    step(1'b0, 4'b0100, 1'b1);
    step(1'b0, 4'b0101, 1'b1); check("wrap_src0", 32'(out_src), 32'd0);
    step(1'b0, 4'b0101, 1'b1); check("wrap_src2", 32'(out_src), 32'd2);
    step(1'b0, 4'b0101, 1'b1); check("wrap_src0b", 32'(out_src), 32'd0);

    // backpressure three cycles, then drain+load in one cycle
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 4'b1111, 1'b0);
      check("bp_src", 32'(out_src), 32'd0);
    end
    step(1'b0, 4'b1111, 1'b1);
    check("bp_release_src", 32'(out_src), 32'd1);

    // idle drain around a single req1 beat
    step(1'b0, 4'b0000, 1'b1);
    d[1] = 8'h5C;
    step(1'b0, 4'b0010, 1'b1);
    check("idle_valid", 32'(out_valid), 32'd1);
    check("idle_data", 32'(out_data), 32'h5C);
    step(1'b0, 4'b0000, 1'b1);
    check("idle_drained", 32'(out_valid), 32'd0);
    step(1'b0, 4'b1111, 1'b1);
    check("idle_next_src", 32'(out_src), 32'd2);

    // reset during a stall discards data and rewinds the pointer
    step(1'b0, 4'b1111, 1'b0);
    step(1'b1, 4'b1111, 1'b0);
    check("rst_stall_valid", 32'(out_valid), 32'd0);
    step(1'b0, 4'b1111, 1'b1);
    check("rst_stall_src", 32'(out_src), 32'd0);

    // random traffic
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++) d[i] = W'($urandom_range(0, 255));
      step($urandom_range(0, 49) == 0, N'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
